// File: rtl/note_player.sv
// note_player: turns the PS/2 make-code stream into queued, fixed-length
// square-wave notes on tone_out. Codes map to note indices 1..21 (C3..B5).
// Notes are buffered in a small FIFO and played back-to-back.
// Optional build macro: NOTE_PLAYER_OCTAVE_SHIFT_EN (shifted keys play one octave up).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | silent, note_idx=0; pops the queue as soon as it is non-empty
// PLAY  | square wave for note_idx; on the last cycle chains into the
//       | next queued note or falls back to IDLE
module note_player #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int NOTE_CYCLES = 12_500_000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_code_ready,
    input  logic       letter_case,
    output logic       tone_out,
    output logic       playing,
    output logic [4:0] note_idx,
    output logic       fifo_full,
    output logic [7:0] drop_cnt
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PLAY = 1'b1;

    // C3 has the longest half period and sizes the tone timer
    localparam int HALF_MAX = CLK_HZ / (2 * 131);
    localparam int TW       = $clog2(HALF_MAX) + 1;
    localparam int DW       = $clog2(NOTE_CYCLES + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);

    localparam logic [DW-1:0] DUR_LOAD  = DW'(NOTE_CYCLES - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    function automatic logic [4:0] key_map(input logic [7:0] code);
        case (code)
            8'h1C: key_map = 5'd1;
            8'h1B: key_map = 5'd2;
            8'h23: key_map = 5'd3;
            8'h2B: key_map = 5'd4;
            8'h34: key_map = 5'd5;
            8'h33: key_map = 5'd6;
            8'h3B: key_map = 5'd7;
            8'h15: key_map = 5'd8;
            8'h1D: key_map = 5'd9;
            8'h24: key_map = 5'd10;
            8'h2D: key_map = 5'd11;
            8'h2C: key_map = 5'd12;
            8'h35: key_map = 5'd13;
            8'h3C: key_map = 5'd14;
            8'h16: key_map = 5'd15;
            8'h1E: key_map = 5'd16;
            8'h26: key_map = 5'd17;
            8'h25: key_map = 5'd18;
            8'h2E: key_map = 5'd19;
            8'h36: key_map = 5'd20;
            8'h3D: key_map = 5'd21;
            default: key_map = 5'd0;
        endcase
    endfunction

    // each entry folds to a constant; no divider is built
    function automatic logic [TW-1:0] half_period(input logic [4:0] idx);
        case (idx)
            5'd1:  half_period = TW'(CLK_HZ / (2 * 131));
            5'd2:  half_period = TW'(CLK_HZ / (2 * 147));
            5'd3:  half_period = TW'(CLK_HZ / (2 * 165));
            5'd4:  half_period = TW'(CLK_HZ / (2 * 175));
            5'd5:  half_period = TW'(CLK_HZ / (2 * 196));
            5'd6:  half_period = TW'(CLK_HZ / (2 * 220));
            5'd7:  half_period = TW'(CLK_HZ / (2 * 247));
            5'd8:  half_period = TW'(CLK_HZ / (2 * 262));
            5'd9:  half_period = TW'(CLK_HZ / (2 * 294));
            5'd10: half_period = TW'(CLK_HZ / (2 * 330));
            5'd11: half_period = TW'(CLK_HZ / (2 * 349));
            5'd12: half_period = TW'(CLK_HZ / (2 * 392));
            5'd13: half_period = TW'(CLK_HZ / (2 * 440));
            5'd14: half_period = TW'(CLK_HZ / (2 * 494));
            5'd15: half_period = TW'(CLK_HZ / (2 * 523));
            5'd16: half_period = TW'(CLK_HZ / (2 * 587));
            5'd17: half_period = TW'(CLK_HZ / (2 * 659));
            5'd18: half_period = TW'(CLK_HZ / (2 * 698));
            5'd19: half_period = TW'(CLK_HZ / (2 * 784));
            5'd20: half_period = TW'(CLK_HZ / (2 * 880));
            5'd21: half_period = TW'(CLK_HZ / (2 * 988));
            default: half_period = TW'(HALF_MAX);
        endcase
    endfunction

    logic [0:0]    state;
    logic [TW-1:0] tone_cnt;
    logic [DW-1:0] dur_cnt;
    logic [4:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [4:0]    map_idx;
    logic [4:0]    push_idx;
    logic [4:0]    head_idx;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          note_done;

    assign map_idx = key_map(scan_code);

`ifdef NOTE_PLAYER_OCTAVE_SHIFT_EN
    assign push_idx = (letter_case && (map_idx != 5'd0) && (map_idx <= 5'd14))
                      ? map_idx + 5'd7 : map_idx;
`else
    logic unused_letter_case;
    assign unused_letter_case = letter_case;
    assign push_idx = map_idx;
`endif

    // pop only looks at registered occupancy, so an IDLE pop never sees
    // a push from the same cycle
    assign head_idx  = mem[rd_ptr];
    assign note_done = (state == S_PLAY) && (dur_cnt == '0);
    assign pop       = (count != '0) && ((state == S_IDLE) || note_done);
    assign push_req  = scan_code_ready && (map_idx != 5'd0);
    assign push_ok   = push_req && (!fifo_full || pop);
    assign playing   = (state == S_PLAY);

    // next occupancy, used for the registered full flag
    always_comb begin
        count_next = count;
        if (push_ok && !pop)
            count_next = count + (AW + 1)'(1);
        else if (!push_ok && pop)
            count_next = count - (AW + 1)'(1);
    end

    // queue storage; contents need no reset since the pointers are cleared
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_idx;
    end

    // queue pointers, occupancy, full flag and saturating drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
            drop_cnt  <= 8'd0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count     <= count_next;
            fifo_full <= (count_next == DEPTH_CNT);
            if (push_req && !push_ok && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // player FSM with down-counting tone and duration timers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            tone_out <= 1'b0;
            note_idx <= 5'd0;
            tone_cnt <= '0;
            dur_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tone_out <= 1'b0;
                    note_idx <= 5'd0;
                    if (pop) begin
                        state    <= S_PLAY;
                        note_idx <= head_idx;
                        tone_cnt <= half_period(head_idx) - TW'(1);
                        dur_cnt  <= DUR_LOAD;
                    end
                end
                S_PLAY: begin
                    if (note_done) begin
                        tone_out <= 1'b0;
                        if (pop) begin
                            note_idx <= head_idx;
                            tone_cnt <= half_period(head_idx) - TW'(1);
                            dur_cnt  <= DUR_LOAD;
                        end else begin
                            state    <= S_IDLE;
                            note_idx <= 5'd0;
                        end
                    end else begin
                        dur_cnt <= dur_cnt - DW'(1);
                        if (tone_cnt == '0) begin
                            tone_out <= ~tone_out;
                            tone_cnt <= half_period(note_idx) - TW'(1);
                        end else begin
                            tone_cnt <= tone_cnt - TW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_player.sv
// tb_note_player: table-driven key map / tone checks plus hand sequences
// for back-to-back play, overflow, full push+pop and mid-note reset.
module tb_note_player;

    localparam int CLK_HZ      = 1_000_000;
    localparam int NOTE_CYCLES = 10_000;
    localparam int FIFO_DEPTH  = 4;

`ifdef NOTE_PLAYER_OCTAVE_SHIFT_EN
    localparam int LC_1C_IDX = 8;
`else
    localparam int LC_1C_IDX = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] scan_code = 8'h00;
    logic       scan_code_ready = 1'b0;
    logic       letter_case = 1'b0;
    logic       tone_out;
    logic       playing;
    logic [4:0] note_idx;
    logic       fifo_full;
    logic [7:0] drop_cnt;

    note_player #(
        .CLK_HZ(CLK_HZ),
        .NOTE_CYCLES(NOTE_CYCLES),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .scan_code(scan_code),
        .scan_code_ready(scan_code_ready),
        .letter_case(letter_case),
        .tone_out(tone_out),
        .playing(playing),
        .note_idx(note_idx),
        .fifo_full(fifo_full),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       lc;
        int         exp_idx;
        bit         chk_half;
    } vec_t;

    vec_t vecs[$];
    int   freq_hz [21] = '{131, 147, 165, 175, 196, 220, 247,
                           262, 294, 330, 349, 392, 440, 494,
                           523, 587, 659, 698, 784, 880, 988};

    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_q[$];
    int model_occ = 0;
    int model_drops = 0;

    int cyc = 0;
    int n_starts = 0, n_rises = 0, n_falls = 0, n_stops = 0;
    int start_cyc = 0, rise_cyc = 0, fall_cyc = 0, stop_cyc = 0;
    logic       prev_p = 1'b0;
    logic       prev_t = 1'b0;
    logic [4:0] prev_i = 5'd0;

    always @(posedge clk) cyc = cyc + 1;

    // event monitor: note starts, tone edges, return to idle
    always @(negedge clk) begin
        if (playing && (!prev_p || note_idx != prev_i)) begin
            n_starts = n_starts + 1;
            start_cyc = cyc;
        end
        if (tone_out && !prev_t) begin
            n_rises = n_rises + 1;
            rise_cyc = cyc;
        end
        if (!tone_out && prev_t) begin
            n_falls = n_falls + 1;
            fall_cyc = cyc;
        end
        if (!playing && prev_p) begin
            n_stops = n_stops + 1;
            stop_cyc = cyc;
        end
        prev_p = playing;
        prev_t = tone_out;
        prev_i = note_idx;
    end

    function automatic int exp_half(input int idx);
        return CLK_HZ / (2 * freq_hz[idx - 1]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // kind: 0 starts, 1 rises, 2 falls, 3 stops
    task automatic wait_count(input string name, input int kind, input int target, input int budget);
        int cur;
        bit ok;
        cur = 0;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            case (kind)
                0: cur = n_starts;
                1: cur = n_rises;
                2: cur = n_falls;
                default: cur = n_stops;
            endcase
            if (cur >= target) ok = 1'b1;
        end
        if (!ok) check({name, "_timeout"}, cur, target);
    endtask

    // one-cycle strobe; the model decides acceptance from its own occupancy
    task automatic strobe(input logic [7:0] code, input logic lc, input int exp_idx, input bit pop_same_edge);
        scan_code = code;
        letter_case = lc;
        scan_code_ready = 1'b1;
        if (exp_idx != 0) begin
            if (model_occ - (pop_same_edge ? 1 : 0) < FIFO_DEPTH) begin
                exp_q.push_back(exp_idx);
                model_occ++;
            end else if (model_drops < 255) begin
                model_drops++;
            end
        end
        @(posedge clk);
        #1;
        scan_code_ready = 1'b0;
        letter_case = 1'b0;
    endtask

    task automatic sb_note(input string name);
        int exp;
        if (exp_q.size() == 0) begin
            check({name, "_unexpected"}, note_idx, 0);
        end else begin
            exp = exp_q.pop_front();
            model_occ--;
            check(name, note_idx, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        model_occ = 0;
        model_drops = 0;
    endtask

    task automatic add_vec(input logic [7:0] code, input logic lc, input int idx, input bit chk);
        vec_t v;
        v.code = code;
        v.lc = lc;
        v.exp_idx = idx;
        v.chk_half = chk;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, rb, fb, sbase, e0, prev_start, s3_start;
        int halves [3] = '{3816, 1515, 506};
        vec_t v;

        add_vec(8'h1C, 1'b0, 1, 1'b0);  add_vec(8'h1B, 1'b0, 2, 1'b0);
        add_vec(8'h23, 1'b0, 3, 1'b0);  add_vec(8'h2B, 1'b0, 4, 1'b1);
        add_vec(8'h34, 1'b0, 5, 1'b0);  add_vec(8'h33, 1'b0, 6, 1'b0);
        add_vec(8'h3B, 1'b0, 7, 1'b1);  add_vec(8'h15, 1'b0, 8, 1'b1);
        add_vec(8'h1D, 1'b0, 9, 1'b1);  add_vec(8'h24, 1'b0, 10, 1'b1);
        add_vec(8'h2D, 1'b0, 11, 1'b1); add_vec(8'h2C, 1'b0, 12, 1'b1);
        add_vec(8'h35, 1'b0, 13, 1'b1); add_vec(8'h3C, 1'b0, 14, 1'b1);
        add_vec(8'h16, 1'b0, 15, 1'b1); add_vec(8'h1E, 1'b0, 16, 1'b1);
        add_vec(8'h26, 1'b0, 17, 1'b1); add_vec(8'h25, 1'b0, 18, 1'b1);
        add_vec(8'h2E, 1'b0, 19, 1'b1); add_vec(8'h36, 1'b0, 20, 1'b1);
        add_vec(8'h3D, 1'b0, 21, 1'b1);
        add_vec(8'h29, 1'b0, 0, 1'b0);  add_vec(8'h5A, 1'b0, 0, 1'b0);
        add_vec(8'h1C, 1'b1, LC_1C_IDX, 1'b1);
        add_vec(8'h16, 1'b1, 15, 1'b1);

        tick(2);
        do_reset();
        check("rst_tone", tone_out, 0);
        check("rst_playing", playing, 0);
        check("rst_idx", note_idx, 0);
        check("rst_full", fifo_full, 0);
        check("rst_drop", drop_cnt, 0);

        // key map, entry latency and first half period per code
        foreach (vecs[k]) begin
            v = vecs[k];
            do_reset();
            base = n_starts;
            strobe(v.code, v.lc, v.exp_idx, 1'b0);
            e0 = cyc;
            if (v.exp_idx != 0) begin
                wait_count($sformatf("start_%02h", v.code), 0, base + 1, 4);
                check($sformatf("latency_%02h", v.code), start_cyc - e0, 1);
                sb_note($sformatf("map_%02h_lc%0d", v.code, v.lc));
                if (v.chk_half) begin
                    rb = n_rises;
                    wait_count($sformatf("rise_%02h", v.code), 1, rb + 1, exp_half(v.exp_idx) + 10);
                    check($sformatf("half_idx%0d", v.exp_idx), rise_cyc - start_cyc, exp_half(v.exp_idx));
                end
                tick(1);
            end else begin
                tick(4);
                check($sformatf("unmapped_%02h_playing", v.code), playing, 0);
                check($sformatf("unmapped_%02h_idx", v.code), note_idx, 0);
                check($sformatf("unmapped_%02h_full", v.code), fifo_full, 0);
                check($sformatf("unmapped_%02h_drop", v.code), drop_cnt, model_drops);
            end
        end

        // single note: latency, half period, length, silence afterwards
        do_reset();
        base = n_starts;
        strobe(8'h15, 1'b0, 8, 1'b0);
        e0 = cyc;
        wait_count("s1_start", 0, base + 1, 4);
        check("s1_latency", start_cyc - e0, 1);
        sb_note("s1_idx");
        rb = n_rises;
        wait_count("s1_rise", 1, rb + 1, 2000);
        check("s1_first_rise", rise_cyc - start_cyc, 1908);
        fb = n_falls;
        wait_count("s1_fall", 2, fb + 1, 2000);
        check("s1_half", fall_cyc - rise_cyc, 1908);
        sbase = n_stops;
        wait_count("s1_stop", 3, sbase + 1, NOTE_CYCLES);
        check("s1_length", stop_cyc - start_cyc, NOTE_CYCLES);
        tick(3);
        check("s1_tone_after", tone_out, 0);
        check("s1_idx_after", note_idx, 0);

        // three notes back-to-back with no idle cycle
        do_reset();
        base = n_starts;
        sbase = n_stops;
        strobe(8'h1C, 1'b0, 1, 1'b0);
        e0 = cyc;
        strobe(8'h24, 1'b0, 10, 1'b0);
        strobe(8'h3D, 1'b0, 21, 1'b0);
        prev_start = 0;
        for (int k = 0; k < 3; k++) begin
            wait_count($sformatf("s2_start%0d", k), 0, base + k + 1, (k == 0) ? 4 : NOTE_CYCLES + 4);
            if (k == 0) check("s2_latency", start_cyc - e0, 1);
            else check($sformatf("s2_chain%0d", k), start_cyc - prev_start, NOTE_CYCLES);
            prev_start = start_cyc;
            sb_note($sformatf("s2_idx%0d", k));
            rb = n_rises;
            wait_count($sformatf("s2_rise%0d", k), 1, rb + 1, halves[k] + 10);
            check($sformatf("s2_first_rise%0d", k), rise_cyc - start_cyc, halves[k]);
            fb = n_falls;
            wait_count($sformatf("s2_fall%0d", k), 2, fb + 1, halves[k] + 10);
            check($sformatf("s2_half%0d", k), fall_cyc - rise_cyc, halves[k]);
        end
        check("s2_no_idle_gap", n_stops - sbase, 0);
        wait_count("s2_stop", 3, sbase + 1, NOTE_CYCLES + 4);
        check("s2_last_length", stop_cyc - prev_start, NOTE_CYCLES);
        tick(1);

        // overflow while playing, then push+pop on a full queue
        do_reset();
        base = n_starts;
        strobe(8'h1B, 1'b0, 2, 1'b0);
        wait_count("s3_start", 0, base + 1, 4);
        sb_note("s3_first");
        s3_start = start_cyc;
        tick(1);
        strobe(8'h15, 1'b0, 8, 1'b0);
        strobe(8'h1D, 1'b0, 9, 1'b0);
        strobe(8'h24, 1'b0, 10, 1'b0);
        strobe(8'h2D, 1'b0, 11, 1'b0);
        strobe(8'h2C, 1'b0, 12, 1'b0);
        check("s3_full", fifo_full, 1);
        check("s3_drop", drop_cnt, model_drops);
        strobe(8'h29, 1'b0, 0, 1'b0);
        check("s3_unmapped_no_drop", drop_cnt, model_drops);
        while (cyc < s3_start + NOTE_CYCLES - 1) tick(1);
        strobe(8'h35, 1'b0, 13, 1'b1);
        check("s3_pushpop_full", fifo_full, 1);
        check("s3_pushpop_drop", drop_cnt, model_drops);
        wait_count("s3_next", 0, base + 2, 4);
        sb_note("s3_second");
        check("s3_back_to_back", start_cyc - s3_start, NOTE_CYCLES);

        // reset mid-note with a full queue
        rb = n_rises;
        wait_count("s5_rise", 1, rb + 1, 2000);
        tick(5);
        check("s5_tone_high", tone_out, 1);
        do_reset();
        check("s5_tone", tone_out, 0);
        check("s5_playing", playing, 0);
        check("s5_idx", note_idx, 0);
        check("s5_full", fifo_full, 0);
        check("s5_drop", drop_cnt, 0);
        tick(4);
        check("s5_queue_empty", playing, 0);
        base = n_starts;
        strobe(8'h16, 1'b0, 15, 1'b0);
        wait_count("s5_start", 0, base + 1, 4);
        sb_note("s5_note");
        rb = n_rises;
        wait_count("s5_rise2", 1, rb + 1, 1000);
        check("s5_half", rise_cyc - start_cyc, 956);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/note_player.md
Name: note_player

Overview:
- Sits directly downstream of the PS/2 keyboard front end and consumes its make-code stream (scan_code / scan_code_ready / letter_case).
- Maps each code to a note index 1..21 (C3..B5), buffers it in a small FIFO, and plays each note as a fixed-length square wave on tone_out.
- Notes play back-to-back in arrival order; tone_out feeds the buzzer/audio pin.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- NOTE_CYCLES, 12_500_000, length of one played note in clk cycles (250 ms at default).
- FIFO_DEPTH, 4, note queue depth; power of two, 2..16.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- scan_code  in  8  PS/2 make code from keyboard stage
- scan_code_ready  in  1  one-cycle strobe; scan_code valid this cycle
- letter_case  in  1  1 = shift/caps active (used only with optional feature)
- tone_out  out  1  square-wave audio output
- playing  out  1  1 while in PLAY state
- note_idx  out  5  index of the note currently playing; 0 when idle
- fifo_full  out  1  queue holds FIFO_DEPTH entries
- drop_cnt  out  8  saturating count of dropped (overflow) notes

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: tone_out=0, playing=0, note_idx=0, fifo_full=0, drop_cnt=0; FIFO emptied; state IDLE. Reset mid-note aborts immediately; tone_out is 0 from the first cycle after reset.
- Key map (combinational, 5-bit result):
  - 16,1E,26,25,2E,36,3D -> 15..21
  - 15,1D,24,2D,2C,35,3C -> 8..14
  - 1C,1B,23,2B,34,33,3B -> 1..7
  - Any other code is unmapped: ignored, not queued, drop_cnt unchanged.
- Push: on scan_code_ready with a mapped code, write the index at the tail in the same clock edge.
  - Accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the new note is discarded and drop_cnt increments, saturating at 255.
- Half-period table: half[n] = CLK_HZ / (2*f[n]), integer division, constant per parameter set.
  - f in Hz: 131,147,165,175,196,220,247, 262,294,330,349,392,440,494, 523,587,659,698,784,880,988.
  - Tone counter width is clog2(max half)+1.
- FSM states and transitions:
  - IDLE: playing=0, tone_out=0, note_idx=0. If FIFO is non-empty, pop, latch note_idx, clear tone and duration counters, go to PLAY. playing rises 1 cycle after the FIFO becomes non-empty; a push and its pop never occur in the same cycle from IDLE.
  - PLAY: tone counter increments each cycle. When it equals half[note_idx]-1 it wraps to 0 and tone_out toggles. tone_out starts at 0 and its first rising edge is half cycles after entry. The duration counter counts 0..NOTE_CYCLES-1.
  - Last PLAY cycle, FIFO non-empty: pop in that cycle, reload note_idx and both counters, force tone_out=0, stay in PLAY. There is no silent gap.
  - Last PLAY cycle, FIFO empty: go to IDLE with tone_out=0.
- Simultaneous push and pop on a full FIFO: both succeed, occupancy unchanged, no drop.
- Pointers wrap modulo FIFO_DEPTH. fifo_full is registered and tracks occupancy exactly.

Optional Feature:
- Macro: NOTE_PLAYER_OCTAVE_SHIFT_EN.
- When defined: a push with letter_case=1 and mapped index 1..14 enqueues index+7 (one octave up). Indices 15..21 are unchanged.
- When undefined: letter_case is ignored and the port is kept unused.

Test Plan:
- Bench parameters: CLK_HZ=1_000_000, NOTE_CYCLES=10_000. All scenarios below use them.
- Reset, then one 0x15 strobe -> playing=1 two edges later, note_idx=8; tone_out half-period 1908 cycles; playing=0 exactly 10_000 cycles after entry; tone_out=0 afterwards.
- Strobes 0x1C, 0x24, 0x3D on consecutive cycles -> notes 1, 10, 21 play back-to-back with no IDLE cycle; half-periods 3816, 1515, 506.
- Six mapped strobes while the first note plays (FIFO_DEPTH=4) -> fifo_full=1; drop_cnt=1 (first pops, four queue, sixth dropped).
- Strobes of unmapped codes 0x29 and 0x5A -> no state change; drop_cnt stays 0.
- Assert reset for one cycle mid-note -> next cycle all outputs are 0 and the FIFO is empty; a subsequent 0x16 plays note 15.
- With NOTE_PLAYER_OCTAVE_SHIFT_EN defined: 0x1C with letter_case=1 -> note_idx=8; 0x16 with letter_case=1 -> note_idx=15.
